// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and types for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_W              = 8;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mem_cmd_t;

  // grant bit 1 belongs to the data requester, bit 0 to instruction fetch
  function automatic logic owner_of(input logic [1:0] grant);
    return grant[1] ? OWN_DC : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface mem_port_arbiter_if;

  logic        if_req_i;
  logic [29:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_rdata_o;

  logic        dc_req_i;
  logic [3:0]  dc_we_i;
  logic [29:0] dc_addr_i;
  logic [31:0] dc_wdata_i;
  logic        dc_done_o;
  logic [31:0] dc_rdata_o;

  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_timeout_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_done_o, if_rdata_o,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    output dc_done_o, dc_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_timeout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_done_o, if_rdata_o,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    input  dc_done_o, dc_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_timeout_o
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rtl/mem_port_arbiter_rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == OWN_DC) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  // abort is taken on the WAIT cycle whose increment brings the counter to TIMEOUT_CYCLES-1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dc_rdata_q, dc_rdata_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       grant;
  logic             pick;

  rr_arbiter2 u_rr (
    .req_i        ({bus.dc_req_i, bus.if_req_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign pick = owner_of(grant);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = pick;
          last_grant_d = pick;
          if (pick == OWN_DC) begin
            cmd_d.addr  = bus.dc_addr_i;
            cmd_d.we    = bus.dc_we_i;
            cmd_d.wdata = bus.dc_wdata_i;
          end else begin
            cmd_d.addr  = bus.if_addr_i;
            cmd_d.we    = 4'b0000;
            cmd_d.wdata = 32'h0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_gnt_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (owner_q == OWN_DC) dc_rdata_d = bus.mem_rdata_i;
          else                   if_rdata_d = bus.mem_rdata_i;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (owner_q == OWN_DC) dc_rdata_d = 32'h0;
            else                   if_rdata_d = 32'h0;
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      cmd_q        <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= 32'h0;
      dc_rdata_q   <= 32'h0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mem_req_o     = (state_q == ST_ISSUE);
  assign bus.mem_addr_o    = cmd_q.addr;
  assign bus.mem_we_o      = cmd_q.we;
  assign bus.mem_wdata_o   = cmd_q.wdata;
  assign bus.mem_timeout_o = timeout_q;
  assign bus.if_done_o     = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign bus.dc_done_o     = (state_q == ST_DONE) && (owner_q == OWN_DC);
  assign bus.if_rdata_o    = if_rdata_q;
  assign bus.dc_rdata_o    = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for the memory port arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        if_req;
    logic [29:0] if_addr;
    logic        dc_req;
    logic [3:0]  dc_we;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        drop_early;
    logic        exp_own;
    logic [29:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] model_if = 32'h0;
  logic [31:0] model_dc = 32'h0;
  vec_t vecs[8];
  vec_t fresh;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.mem_req_o && n < 10);
    if (!bus.mem_req_o) check("req_wait_bound", 32'(bus.mem_req_o), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.if_done_o || bus.dc_done_o)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_owner", 32'(bus.dc_done_o), 32'(mon_e.own));
        check("sb_rdata", mon_e.own ? bus.dc_rdata_o : bus.if_rdata_o, mon_e.rdata);
        check("sb_timeout", 32'(bus.mem_timeout_o), 32'(mon_e.tmo));
        check("sb_single_done", 32'(bus.if_done_o & bus.dc_done_o), 32'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    bus.if_req_i   = v.if_req;
    bus.if_addr_i  = v.if_addr;
    bus.dc_req_i   = v.dc_req;
    bus.dc_we_i    = v.dc_we;
    bus.dc_addr_i  = v.dc_addr;
    bus.dc_wdata_i = v.dc_wdata;
    wait_req(n);
    check("req_latency", 32'(n), 32'd1);
    check("issue_addr", {2'b0, bus.mem_addr_o}, {2'b0, v.exp_addr});
    check("issue_we", 32'(bus.mem_we_o), 32'(v.exp_we));
    if (v.exp_own == OWN_DC) check("issue_wdata", bus.mem_wdata_o, v.exp_wdata);
    for (int i = 0; i < v.gnt_dly; i++) begin
      bus.if_addr_i    = ~v.if_addr;
      bus.dc_addr_i    = ~v.dc_addr;
      bus.dc_we_i      = ~v.dc_we;
      bus.dc_wdata_i   = ~v.dc_wdata;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hBAD0_0000 + 32'(i);
      tick();
      check("hold_req", 32'(bus.mem_req_o), 32'd1);
      check("hold_addr", {2'b0, bus.mem_addr_o}, {2'b0, v.exp_addr});
      check("hold_we", 32'(bus.mem_we_o), 32'(v.exp_we));
      if (v.exp_own == OWN_DC) check("hold_wdata", bus.mem_wdata_o, v.exp_wdata);
      check("issue_no_done", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
    end
    bus.mem_rvalid_i = 1'b0;
    bus.mem_gnt_i    = 1'b1;
    if (v.drop_early) begin
      bus.if_req_i = 1'b0;
      bus.dc_req_i = 1'b0;
    end
    tick();
    bus.mem_gnt_i = 1'b0;
    check("wait_req_low", 32'(bus.mem_req_o), 32'd0);
    for (int i = 0; i < v.rv_dly; i++) begin
      check("wait_no_done", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
      tick();
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = v.rdata;
    sb.push_back('{own: v.exp_own, rdata: v.rdata, tmo: 1'b0});
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h5A5A_5A5A;
    if (v.exp_own == OWN_DC) model_dc = v.rdata;
    else                     model_if = v.rdata;
    check("done_owner", 32'(v.exp_own == OWN_DC ? bus.dc_done_o : bus.if_done_o), 32'd1);
    check("done_other", 32'(v.exp_own == OWN_DC ? bus.if_done_o : bus.dc_done_o), 32'd0);
    check("done_if_rdata", bus.if_rdata_o, model_if);
    check("done_dc_rdata", bus.dc_rdata_o, model_dc);
    bus.if_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
    tick();
    check("post_done_low", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
    check("post_if_rdata_hold", bus.if_rdata_o, model_if);
    check("post_dc_rdata_hold", bus.dc_rdata_o, model_dc);
    tick();
    check("no_double_issue", 32'(bus.mem_req_o), 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_if = 32'h0;
    model_dc = 32'h0;
  endtask

  initial begin
    int n;
    int n_if;
    int n_dc;
    logic own;

    vecs[0] = '{1'b1, 30'h100, 1'b0, 4'h0, 30'h0,   32'h0,        0, 1, 32'hDEADBEEF, 1'b0, OWN_IF, 30'h100, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 30'h0,   1'b1, 4'h0, 30'h200, 32'h0,        0, 0, 32'h11112222, 1'b0, OWN_DC, 30'h200, 4'h0, 32'h0};
    vecs[2] = '{1'b1, 30'h300, 1'b1, 4'h0, 30'h400, 32'h0,        2, 0, 32'h33334444, 1'b0, OWN_IF, 30'h300, 4'h0, 32'h0};
    vecs[3] = '{1'b1, 30'h310, 1'b1, 4'hF, 30'h500, 32'hCAFEF00D, 1, 2, 32'h0,        1'b0, OWN_DC, 30'h500, 4'hF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 30'h0,   1'b1, 4'h3, 30'h600, 32'h0000ABCD, 5, 0, 32'h55556666, 1'b0, OWN_DC, 30'h600, 4'h3, 32'h0000ABCD};
    vecs[5] = '{1'b1, 30'h700, 1'b1, 4'h0, 30'h800, 32'h0,        0, 1, 32'h0BADCAFE, 1'b1, OWN_IF, 30'h700, 4'h0, 32'h0};
    vecs[6] = '{1'b1, 30'h900, 1'b0, 4'h0, 30'h0,   32'h0,        0, 3, 32'h12345678, 1'b0, OWN_IF, 30'h900, 4'h0, 32'h0};
    vecs[7] = '{1'b1, 30'h910, 1'b1, 4'h0, 30'hA00, 32'h0,        0, 0, 32'h77778888, 1'b0, OWN_DC, 30'hA00, 4'h0, 32'h0};

    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.dc_req_i = 1'b0; bus.dc_we_i = '0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    tick();
    tick();
    check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_mem_addr", {2'b0, bus.mem_addr_o}, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_dones", 32'({bus.if_done_o, bus.dc_done_o, bus.mem_timeout_o}), 32'd0);
    check("rst_rdata", bus.if_rdata_o | bus.dc_rdata_o, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    bus.dc_req_i = 1'b1; bus.dc_addr_i = 30'h3C0; bus.dc_we_i = 4'h0;
    wait_req(n);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("tmo_no_done", 32'(bus.dc_done_o | bus.if_done_o), 32'd0);
      check("tmo_no_pulse", 32'(bus.mem_timeout_o), 32'd0);
      if (i < 6) tick();
    end
    sb.push_back('{own: OWN_DC, rdata: 32'h0, tmo: 1'b1});
    tick();
    check("tmo_pulse", 32'(bus.mem_timeout_o), 32'd1);
    check("tmo_done", 32'(bus.dc_done_o), 32'd1);
    check("tmo_rdata_zero", bus.dc_rdata_o, 32'd0);
    model_dc = 32'h0;
    bus.dc_req_i = 1'b0;
    tick();
    check("tmo_pulse_end", 32'(bus.mem_timeout_o | bus.dc_done_o), 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid_i = 1'b0;
    check("stray_rv_no_done", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
    tick();
    check("stray_rv_no_done2", 32'(bus.if_done_o | bus.dc_done_o | bus.mem_req_o), 32'd0);
    check("stray_rv_rdata", bus.dc_rdata_o, 32'd0);

    reset_pulse();
    n_if = 0; n_dc = 0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h1000;
    bus.dc_req_i = 1'b1; bus.dc_addr_i = 30'h2000; bus.dc_we_i = 4'h0; bus.dc_wdata_i = 32'h0;
    for (int k = 0; k < 6; k++) begin
      own = (k % 2 == 0) ? OWN_DC : OWN_IF;
      wait_req(n);
      check("rr_order_addr", {2'b0, bus.mem_addr_o},
            own == OWN_DC ? 32'h2000 + 32'(n_dc) : 32'h1000 + 32'(n_if));
      bus.mem_gnt_i = 1'b1;
      tick();
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hA000_0000 + 32'(k);
      sb.push_back('{own: own, rdata: 32'hA000_0000 + 32'(k), tmo: 1'b0});
      tick();
      bus.mem_rvalid_i = 1'b0;
      check("rr_done", 32'(own == OWN_DC ? bus.dc_done_o : bus.if_done_o), 32'd1);
      if (own == OWN_DC) begin bus.dc_req_i = 1'b0; n_dc++; model_dc = 32'hA000_0000 + 32'(k); end
      else               begin bus.if_req_i = 1'b0; n_if++; model_if = 32'hA000_0000 + 32'(k); end
      tick();
      if (own == OWN_DC && n_dc < 3) begin bus.dc_req_i = 1'b1; bus.dc_addr_i = 30'h2000 + 30'(n_dc); end
      if (own == OWN_IF && n_if < 3) begin bus.if_req_i = 1'b1; bus.if_addr_i = 30'h1000 + 30'(n_if); end
    end
    tick();
    check("rr_idle_after", 32'(bus.mem_req_o), 32'd0);

    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h123;
    wait_req(n);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_addr", {2'b0, bus.mem_addr_o}, 32'd0);
    check("async_rst_rdata", bus.if_rdata_o | bus.dc_rdata_o, 32'd0);
    check("async_rst_outs", 32'({bus.mem_req_o, bus.if_done_o, bus.dc_done_o, bus.mem_timeout_o}), 32'd0);
    bus.if_req_i = 1'b0;
    model_if = 32'h0; model_dc = 32'h0;
    tick();
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1357_9BDF;
    tick();
    bus.mem_rvalid_i = 1'b0;
    check("late_rv_no_done", 32'(bus.if_done_o | bus.dc_done_o), 32'd0);
    tick();
    check("late_rv_idle", 32'(bus.if_done_o | bus.dc_done_o | bus.mem_req_o), 32'd0);
    fresh = '{1'b1, 30'hB00, 1'b1, 4'h1, 30'hC00, 32'h000000EE, 0, 0, 32'h2468ACE0, 1'b0, OWN_DC, 30'hC00, 4'h1, 32'h000000EE};
    run_vec(fresh);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, WAIT-state cycles without response before abort (range 2..255).
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 if_req_i  input  1  instruction-fetch read request; held high until if_done_o.
REQ-005 if_addr_i  input  30 [31:2]  instruction word address.
REQ-006 if_done_o  output  1  one-cycle completion pulse for the instruction requester.
REQ-007 if_rdata_o  output  32  fetched word; valid while if_done_o is high.
REQ-008 dc_req_i  input  1  data request; held high until dc_done_o.
REQ-009 dc_we_i  input  4  byte write enables; 4'b0000 = read.
REQ-010 dc_addr_i  input  30 [31:2]  data word address.
REQ-011 dc_wdata_i  input  32  store data.
REQ-012 dc_done_o  output  1  one-cycle completion pulse for the data requester.
REQ-013 dc_rdata_o  output  32  load word; valid while dc_done_o is high.
REQ-014 mem_req_o  output  1  memory port request, held until accepted.
REQ-015 mem_addr_o  output  30 [31:2]  latched address of owner.
REQ-016 mem_we_o  output  4  latched byte enables (0 for instruction fetch).
REQ-017 mem_wdata_o  output  32  latched store data.
REQ-018 mem_gnt_i  input  1  memory accepts the request this cycle.
REQ-019 mem_rvalid_i  input  1  response valid, for reads and writes.
REQ-020 mem_rdata_i  input  32  response read data.
REQ-021 mem_timeout_o  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-022 The block SHALL implement a 4-state FSM: IDLE, ISSUE, WAIT, DONE, with one memory transaction outstanding at most.
REQ-023 IDLE: when any request is high, the block SHALL select an owner, latch its addr/we/wdata, and move to ISSUE; otherwise it stays in IDLE.
REQ-024 Only one requester high -> that requester wins; both high -> the one NOT granted last wins (round-robin); last_grant updates at each grant.
REQ-025 ISSUE: mem_req_o = 1 with latched fields; on mem_gnt_i the block moves to WAIT and clears the timeout counter.
REQ-026 mem_rvalid_i SHALL be ignored in IDLE, ISSUE and DONE.
REQ-027 WAIT: on mem_rvalid_i the block latches mem_rdata_i into the owner's rdata register and moves to DONE.
REQ-028 WAIT: the counter increments each cycle without mem_rvalid_i; when it reaches TIMEOUT_CYCLES-1, the block latches rdata = 0, pulses mem_timeout_o, and moves to DONE.
REQ-029 DONE: the owner's done output SHALL be high for exactly one cycle; the block then returns to IDLE.
REQ-030 Latency: request sampled in IDLE at cycle t -> mem_req_o high at t+1; mem_rvalid_i at cycle r -> done high at r+1.
REQ-031 Requesters drop req the cycle after done; IDLE samples requests no earlier than the cycle after DONE, so no double issue occurs.
REQ-032 A requester dropping req mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-033 Latched mem_* fields SHALL stay stable from ISSUE until DONE, regardless of input changes.
REQ-034 rdata outputs SHALL hold their last value outside done cycles; the non-owner's done stays 0.

Reset
REQ-035 On rst_i the block SHALL asynchronously enter IDLE with last_grant = instruction (data wins the first tie), counter = 0, and all outputs and latched fields = 0.
REQ-036 Reset mid-transaction SHALL drop the in-flight transaction silently (no done pulse); a late mem_rvalid_i after reset is ignored.

Structure
REQ-037 FSM state encodings, owner encoding (OWN_IF = 0, OWN_DC = 1), and the TIMEOUT_CYCLES default SHALL live in the shared core package/header.
REQ-038 The 2-way round-robin pick SHALL be a sub-module rr_arbiter2 (req[1:0], last_grant in, one-hot grant out, combinational); FSM, latches and counter stay in mem_port_arbiter.

Verification
REQ-039 Single fetch: if_req_i = 1, addr = 30'h100; mem_gnt_i at t+1, mem_rvalid_i at t+3 with rdata 32'hDEADBEEF -> mem_we_o = 0, if_done_o at t+4 with if_rdata_o = 32'hDEADBEEF, dc_done_o stays 0.
REQ-040 Simultaneous requests from reset, each run three back-to-back transactions -> grants in order DC, IF, DC, IF, DC, IF.
REQ-041 Store: dc_we_i = 4'b0011, wdata = 32'h0000ABCD; gnt delayed 5 cycles -> mem_req_o held 5 cycles with stable fields, dc_done_o one cycle after rvalid.
REQ-042 Timeout, TIMEOUT_CYCLES = 8, no mem_rvalid_i -> after 7 WAIT cycles: mem_timeout_o pulse, done pulse with rdata 0, FSM back to IDLE; a later stray rvalid causes no done pulse.
REQ-043 rst_i asserted in WAIT -> outputs 0 immediately (asynchronously); rvalid next cycle yields no done; a fresh request after reset is served normally.
